// File: rtl/cliff_pkg.sv
`default_nettype none
// ============================================================================
// cliff_pkg : shared 7-segment codes, digit count and BCD type for the cliff game
// Rev 1.0
// ============================================================================
package cliff_pkg;

  localparam int NUM_DIGITS = 4;

  typedef logic [3:0] bcd_t;

  // Active-low cathodes, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  function automatic logic [6:0] seg_encode(input bcd_t d);
    logic [6:0] s;
    case (d)
      4'd0:    s = SEG_0;
      4'd1:    s = SEG_1;
      4'd2:    s = SEG_2;
      4'd3:    s = SEG_3;
      4'd4:    s = SEG_4;
      4'd5:    s = SEG_5;
      4'd6:    s = SEG_6;
      4'd7:    s = SEG_7;
      4'd8:    s = SEG_8;
      4'd9:    s = SEG_9;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

endpackage
`default_nettype wire

// File: rtl/score_display_if.sv
`default_nettype none
// ============================================================================
// score_display_if : game-core events/levels in, multiplexed display pins out
// Rev 1.0
// ============================================================================
interface score_display_if;
  logic       score_inc;
  logic       score_clr;
  logic       started;
  logic       lose;
  logic [6:0] seg;
  logic [3:0] an;
  logic       dp;

  modport master (
    output score_inc, score_clr, started, lose,
    input  seg, an, dp
  );

  modport slave (
    input  score_inc, score_clr, started, lose,
    output seg, an, dp
  );
endinterface
`default_nettype wire

// File: rtl/bcd_counter4.sv
`default_nettype none
// ============================================================================
// bcd_counter4 : 4-digit BCD counter with sync clear, increment and saturation
// Rev 1.0
// ============================================================================
module bcd_counter4
  import cliff_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clr_i,
  input  logic                  inc_i,
  output bcd_t [NUM_DIGITS-1:0] digits_o,
  output logic                  all_nines_o
);

  bcd_t [NUM_DIGITS-1:0] digits_q;
  bcd_t [NUM_DIGITS-1:0] digits_d;
  logic                  nines;
  logic                  carry;

  always_comb begin
    nines = 1'b1;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      nines = nines && (digits_q[k] == 4'd9);
    end

    // Carry ripples through every 9 in the same cycle; saturate at all nines
    digits_d = digits_q;
    carry    = inc_i && !nines;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (carry) begin
        if (digits_q[k] == 4'd9) begin
          digits_d[k] = 4'd0;
        end else begin
          digits_d[k] = digits_q[k] + 4'd1;
          carry       = 1'b0;
        end
      end
    end

    if (clr_i) begin
      digits_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      digits_q <= '0;
    end else begin
      digits_q <= digits_d;
    end
  end

  assign digits_o    = digits_q;
  assign all_nines_o = nines;

endmodule
`default_nettype wire

// File: rtl/score_display.sv
`default_nettype none
// ============================================================================
// score_display : saturating BCD score, multiplexed onto a 4-digit 7-seg display
// Rev 1.0
// ============================================================================
module score_display
  import cliff_pkg::*;
#(
  parameter int unsigned SCAN_DIV    = 32'h20000,
  parameter logic [15:0] BLINK_TICKS = 16'd256
) (
  input  logic           clk,
  input  logic           reset,
  score_display_if.slave bus
);

  bcd_t [NUM_DIGITS-1:0] digits;
  logic [15:0]           digits_flat;
  logic                  all_nines;
  logic                  inc_req;

  assign inc_req = bus.score_inc && !bus.lose && !all_nines;

  bcd_counter4 u_counter (
    .clk         (clk),
    .reset       (reset),
    .clr_i       (bus.score_clr),
    .inc_i       (inc_req),
    .digits_o    (digits),
    .all_nines_o (all_nines)
  );

  logic [31:0] scan_cnt_q, scan_cnt_d;
  logic [1:0]  idx_q, idx_d;
  logic [15:0] blink_cnt_q, blink_cnt_d;
  logic        blink_on_q, blink_on_d;
  logic [6:0]  seg_q, seg_d;
  logic [3:0]  an_q, an_d;
  logic        dp_q, dp_d;
  logic        tick;
  logic        blank_sel;

  assign digits_flat = digits;

  always_comb begin
    tick        = (scan_cnt_q == SCAN_DIV - 32'd1);
    scan_cnt_d  = tick ? 32'd0 : scan_cnt_q + 32'd1;
    idx_d       = tick ? idx_q + 2'd1 : idx_q;

    blink_cnt_d = blink_cnt_q;
    blink_on_d  = blink_on_q;
    if (!bus.lose) begin
      blink_cnt_d = 16'd0;
      blink_on_d  = 1'b1;
    end else if (tick) begin
      if (blink_cnt_q == BLINK_TICKS - 16'd1) begin
        blink_cnt_d = 16'd0;
        blink_on_d  = !blink_on_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 16'd1;
      end
    end

    // A digit is a leading zero when it and every digit above it are zero
    blank_sel = (idx_q != 2'd0) && ((digits_flat >> {idx_q, 2'b00}) == 16'd0);
    seg_d     = blank_sel ? SEG_BLANK : seg_encode(digits[idx_q]);
    an_d      = blink_on_q ? ~(4'b0001 << idx_q) : 4'b1111;
    dp_d      = !(blink_on_q && !bus.started && !bus.lose && (idx_q == 2'd0));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      scan_cnt_q  <= 32'd0;
      idx_q       <= 2'd0;
      blink_cnt_q <= 16'd0;
      blink_on_q  <= 1'b1;
      seg_q       <= SEG_BLANK;
      an_q        <= 4'b1111;
      dp_q        <= 1'b1;
    end else begin
      scan_cnt_q  <= scan_cnt_d;
      idx_q       <= idx_d;
      blink_cnt_q <= blink_cnt_d;
      blink_on_q  <= blink_on_d;
      seg_q       <= seg_d;
      an_q        <= an_d;
      dp_q        <= dp_d;
    end
  end

  assign bus.seg = seg_q;
  assign bus.an  = an_q;
  assign bus.dp  = dp_q;

endmodule
`default_nettype wire

// File: tb/tb_score_display.sv
`default_nettype none
// ============================================================================
// tb_score_display : vector table plus cycle scoreboard for score_display
// Rev 1.0
// ============================================================================
module tb_score_display;

  localparam int SD = 4;
  localparam int BT = 2;

  logic clk;
  logic reset;

  score_display_if bus ();

  score_display #(
    .SCAN_DIV    (SD),
    .BLINK_TICKS (16'(BT))
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [6:0] seg;
    logic [3:0] an;
    logic       dp;
    bit         care_sd;
  } exp_t;

  typedef struct {
    int              n_inc;
    bit              clr_too;
    logic [3:0][6:0] seg;   // {digit3, digit2, digit1, digit0}
  } vec_t;

  exp_t       sb_q[$];
  int         checks = 0;
  int         errors = 0;
  logic [6:0] seg_tbl [10];

  int m_score, m_cnt, m_idx, m_bcnt;
  bit m_bon;

  function automatic logic [6:0] disp_seg(input int score, input int idx);
    int p = 1;
    for (int i = 0; i < idx; i++) p = p * 10;
    if (idx > 0 && score < p) return 7'b1111111;
    return seg_tbl[(score / p) % 10];
  endfunction

  // Drive one clock of stimulus; the model predicts what the outputs register at this edge
  task automatic cycle(input bit r, input bit inc, input bit clr, input bit st, input bit lo);
    exp_t       e;
    bit         tick;
    logic [3:0] one = 4'b0001;
    reset         = r;
    bus.score_inc = inc;
    bus.score_clr = clr;
    bus.started   = st;
    bus.lose      = lo;
    @(posedge clk);
    if (r) begin
      e = '{seg: 7'b1111111, an: 4'b1111, dp: 1'b1, care_sd: 1'b1};
      m_score = 0; m_cnt = 0; m_idx = 0; m_bcnt = 0; m_bon = 1'b1;
    end else begin
      e.an      = m_bon ? ~(one << m_idx) : 4'b1111;
      e.seg     = disp_seg(m_score, m_idx);
      e.dp      = (m_bon && !st && !lo && m_idx == 0) ? 1'b0 : 1'b1;
      e.care_sd = m_bon;
      if (clr) m_score = 0;
      else if (inc && !lo && m_score < 9999) m_score = m_score + 1;
      tick  = (m_cnt == SD - 1);
      m_cnt = tick ? 0 : m_cnt + 1;
      if (lo) begin
        if (tick) begin
          if (m_bcnt == BT - 1) begin
            m_bcnt = 0;
            m_bon  = !m_bon;
          end else begin
            m_bcnt = m_bcnt + 1;
          end
        end
      end else begin
        m_bcnt = 0;
        m_bon  = 1'b1;
      end
      if (tick) m_idx = (m_idx + 1) % 4;
    end
    sb_q.push_back(e);
    #1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      checks++;
      if (bus.an !== e.an || (e.care_sd && (bus.seg !== e.seg || bus.dp !== e.dp))) begin
        errors++;
        if (errors <= 20)
          $display("FAIL scoreboard t=%0t: an=%b seg=%b dp=%b, expected an=%b seg=%b dp=%b",
                   $time, bus.an, bus.seg, bus.dp, e.an, e.seg, e.dp);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Run one full frame and check every selected digit against the expected pattern
  task automatic frame_check(input string name, input logic [3:0][6:0] exp_seg, input bit st);
    logic [3:0] seen = 4'b0000;
    int         k;
    for (int c = 0; c < 4 * SD; c++) begin
      cycle(1'b0, 1'b0, 1'b0, st, 1'b0);
      case (bus.an)
        4'b1110: k = 0;
        4'b1101: k = 1;
        4'b1011: k = 2;
        4'b0111: k = 3;
        default: k = -1;
      endcase
      if (k < 0) begin
        check({name, " anode"}, {28'd0, bus.an}, 32'hE);
      end else begin
        seen[k] = 1'b1;
        check($sformatf("%s digit%0d", name, k), {25'd0, bus.seg}, {25'd0, exp_seg[k]});
      end
    end
    check({name, " all digits scanned"}, {28'd0, seen}, 32'hF);
  endtask

  vec_t vecs [6];
  int   off;
  int   guard;

  initial begin
    #2000000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    seg_tbl = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
    vecs[0] = '{123,   1'b0, {7'b1111111, 7'b1111001, 7'b0100100, 7'b0110000}};
    vecs[1] = '{100,   1'b0, {7'b1111111, 7'b1111001, 7'b1000000, 7'b1000000}};
    vecs[2] = '{1000,  1'b0, {7'b1111001, 7'b1000000, 7'b1000000, 7'b1000000}};
    vecs[3] = '{10001, 1'b0, {7'b0010000, 7'b0010000, 7'b0010000, 7'b0010000}};
    vecs[4] = '{42,    1'b1, {7'b1111111, 7'b1111111, 7'b1111111, 7'b1000000}};
    vecs[5] = '{5,     1'b0, {7'b1111111, 7'b1111111, 7'b1111111, 7'b0010010}};

    reset = 1'b1;
    bus.score_inc = 1'b0; bus.score_clr = 1'b0; bus.started = 1'b0; bus.lose = 1'b0;

    // Reset, then idle before start: ready dot on digit 0, upper digits blank
    repeat (3) cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("reset an", {28'd0, bus.an}, 32'hF);
    check("reset seg", {25'd0, bus.seg}, 32'h7F);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("post-reset an", {28'd0, bus.an}, 32'hE);
    check("post-reset seg", {25'd0, bus.seg}, 32'h40);
    check("post-reset dp", {31'd0, bus.dp}, 32'h0);
    repeat (4 * SD) cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    for (int v = 0; v < 6; v++) begin
      cycle(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      for (int i = 0; i < vecs[v].n_inc; i++) cycle(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
      if (vecs[v].clr_too) cycle(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
      frame_check($sformatf("vec%0d", v), vecs[v].seg, 1'b1);
    end

    // Loss with score 0005: increments ignored, display blinks 8 on / 8 off
    for (int c = 0; c < 16; c++) cycle(1'b0, (c % 3) == 0, 1'b0, 1'b1, 1'b1);
    off = 0;
    for (int c = 0; c < 32; c++) begin
      cycle(1'b0, (c % 5) == 0, 1'b0, 1'b1, 1'b1);
      if (bus.an === 4'b1111) off++;
    end
    check("blink off cycles in 32", off, 16);
    guard = 0;
    while (!m_bon && guard < 40) begin
      cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
      guard++;
    end
    check("blink visible phase reached", {31'd0, guard < 40}, 32'h1);
    frame_check("after loss", vecs[5].seg, 1'b1);

    // Reset during the blink-off phase with count 0077
    cycle(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    repeat (77) cycle(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    guard = 0;
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    while (bus.an !== 4'b1111 && guard < 40) begin
      cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
      guard++;
    end
    check("blink off phase reached", {31'd0, guard < 40}, 32'h1);
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    check("mid-blink reset an", {28'd0, bus.an}, 32'hF);
    check("mid-blink reset seg", {25'd0, bus.seg}, 32'h7F);
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    check("after mid-blink reset an", {28'd0, bus.an}, 32'hE);
    check("after mid-blink reset seg", {25'd0, bus.seg}, 32'h40);
    frame_check("cleared by reset", vecs[4].seg, 1'b1);

    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/score_display.md
# score_display

Downstream display stage of the cliff game. Holds the player's score as a saturating 4-digit BCD count, fed by one-cycle event pulses from the game core. Time-multiplexes the score onto the board's four-digit, common-anode 7-segment display. Signals game state through a decimal-point "ready" indicator before start and a whole-display blink after a loss.

## Interface
Parameters:
- SCAN_DIV, 32'h20000: clk cycles each digit stays selected; legal range ≥ 2.
- BLINK_TICKS, 16'd256: digit-scan ticks per blink half-period while lost; legal range ≥ 1.

Ports:
- clk  input  1  system clock; every register updates on its rising edge.
- reset  input  1  synchronous, active-high; sampled on the rising edge of clk.
- score_inc  input  1  one-cycle pulse; add 1 to the score.
- score_clr  input  1  one-cycle pulse; clear the score to 0000.
- started  input  1  game running; level input.
- lose  input  1  game lost; level input.
- seg  output  7  cathodes, active-low, bit order {g,f,e,d,c,b,a}.
- an  output  4  anodes, active-low; an[0] is the rightmost digit.
- dp  output  1  decimal point, active-low.

## Operation
Score counter:
- Four BCD digits d3..d0, each 0–9; the count range is 0000–9999.
- Priority on each edge: reset, then score_clr, then score_inc.
- score_inc is ignored while lose=1.
- Saturates at 9999: an increment at 9999 leaves the count at 9999.
- Carry ripples in the same cycle: 0099+1 becomes 0100, and 0999+1 becomes 1000.

Scan:
- scan_cnt counts 0..SCAN_DIV-1 and then returns to 0.
- A tick is the cycle in which scan_cnt = SCAN_DIV-1.
- On each tick, digit index idx advances 0→1→2→3→0.

Anode and cathode selection:
- an is the active-low one-hot of idx: idx 0 gives 4'b1110, idx 3 gives 4'b0111.
- seg is the encoding of d[idx]:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
- Leading-zero blanking: digit k>0 shows seg=1111111 when dk and every higher digit are 0. Digit 0 is never blanked.

Decimal point:
- dp=0 only when started=0, lose=0 and idx=0.
- dp=1 in every other case.

Blink:
- While lose=1, blink_cnt counts ticks.
- blink_on toggles each time blink_cnt reaches BLINK_TICKS-1; blink_cnt then returns to 0.
- While blink_on=0, an=1111, and seg and dp are don't-care.
- When lose falls, blink_cnt clears to 0 and blink_on sets to 1 on the next edge.
- blink_on resets to 1, so the display is visible at the first moment of a loss.

Reset:
- Synchronous reset clears score, scan_cnt, idx and blink_cnt, and sets blink_on=1.
- The registered outputs go to seg=1111111, an=1111, dp=1.
- Reset mid-scan or mid-blink restarts at idx 0 with no residual state.

## Timing
- seg, an and dp are registered.
- Each output reflects the internal state as of the previous edge.
- Reset released at edge R: at edge R+1 the outputs show idx 0 (an=1110, seg=digit-0 code).
- score_inc sampled at edge N: the BCD value updates at N; seg shows the new digit at N+1, if that digit is selected.
- The idx change on the tick edge appears on an one edge later.
- Each digit is therefore displayed for exactly SCAN_DIV cycles.
- A full frame takes 4·SCAN_DIV cycles: 5.24 ms at 100 MHz with the default SCAN_DIV.
- score_clr and score_inc together: score_clr wins and the result is 0000.
- Pulses arriving back-to-back on consecutive cycles each count.

## Structure
- Shared package cliff_pkg holds:
  - the ten SEG_* digit codes and SEG_BLANK=7'b1111111;
  - NUM_DIGITS=4;
  - the bcd_t 4-bit type.
- Sub-module bcd_counter4:
  - synchronous clear, increment and saturate;
  - outputs the four digits plus an all_nines flag.
- score_display instantiates bcd_counter4 and implements scan, blank, blink and output registers in its own logic.

## Test plan
Every scenario runs with SCAN_DIV=4 and BLINK_TICKS=2.

- Reset held for 3 cycles, then released with started=0 → 1 cycle later an=1110, seg=1000000, dp=0. Each an pattern lasts 4 cycles, and digits 1–3 show seg=1111111.
- 123 score_inc pulses, started=1 → digits read 0,1,2,3 at idx 3..0. an=0111 shows blank; an=1011 shows 1111001; an=1101 shows 0100100; an=1110 shows 0110000. dp=1 throughout.
- Preload 9998, then 3 pulses → count holds at 9999, and all four digits show 0010000.
- score_inc and score_clr in the same cycle with count 0042 → count 0000, and only digit 0 is lit.
- lose=1 with score 0005 → an alternates: 8 cycles scanning, then 8 cycles of 1111. score_inc pulses during the loss leave the count at 0005. When lose falls, scanning resumes with no blanked frame.
- reset pulsed during a blink-off phase with count 0077 → next cycle seg=1111111, an=1111, count 0000. One cycle after release, an=1110.
